// File: rtl/imm_encoder_pkg.sv
// Shared immediate-encoding definitions: format codes, field placement and fit/extension helpers.
// Used by the encoder datapath, its fit checker and anything that needs to undo the packing.
package imm_encoder_pkg;

  typedef enum logic [1:0] {
    CTRL_I  = 2'b00,
    CTRL_D  = 2'b01,
    CTRL_B  = 2'b10,
    CTRL_CB = 2'b11
  } ctrl_t;

  localparam int BUS_W = 64;
  localparam int IMM_W = 26;
  localparam int ERR_W = 8;

  // Field position (LSB within Imm26) and width for each format.
  localparam int I_LSB  = 10;
  localparam int I_W    = 12;
  localparam int D_LSB  = 12;
  localparam int D_W    = 9;
  localparam int B_LSB  = 0;
  localparam int B_W    = 26;
  localparam int CB_LSB = 5;
  localparam int CB_W   = 19;

  localparam logic [ERR_W-1:0] ERR_MAX = '1;

  function automatic logic fitsUnsigned(input logic [BUS_W-1:0] v, input int unsigned w);
    return (v >> w) == '0;
  endfunction

  // Everything from the field's sign bit upward must be a copy of that bit.
  function automatic logic fitsSigned(input logic [BUS_W-1:0] v, input int unsigned w);
    logic [BUS_W-1:0] s;
    s = $signed(v) >>> (w - 1);
    return (s == '0) || (&s);
  endfunction

  function automatic logic [BUS_W-1:0] extendImm(input logic [IMM_W-1:0] imm26, input ctrl_t ctrl);
    logic [BUS_W-1:0] r;
    r = '0;
    case (ctrl)
      CTRL_I:  r = {{(BUS_W-I_W){1'b0}}, imm26[I_LSB +: I_W]};
      CTRL_D:  r = {{(BUS_W-D_W){imm26[D_LSB+D_W-1]}}, imm26[D_LSB +: D_W]};
      CTRL_B:  r = {{(BUS_W-B_W){imm26[B_LSB+B_W-1]}}, imm26[B_LSB +: B_W]};
      CTRL_CB: r = {{(BUS_W-CB_W){imm26[CB_LSB+CB_W-1]}}, imm26[CB_LSB +: CB_W]};
      default: r = '0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/imm_encoder_if.sv
// Request/result bundle of the immediate encoder; master drives requests and consumes results.
// Both sides use valid/ready, a transfer happens on the edge where valid and ready are both high.
interface imm_encoder_if;
  import imm_encoder_pkg::*;

  logic             InValid;
  logic             InReady;
  logic [BUS_W-1:0] BusImm;
  ctrl_t            Ctrl;
  logic             OutValid;
  logic             OutReady;
  logic [IMM_W-1:0] Imm26;
  logic             Fit;
  logic             ClearErr;
  logic [ERR_W-1:0] ErrCount;

  modport master (
    output InValid, BusImm, Ctrl, OutReady, ClearErr,
    input  InReady, OutValid, Imm26, Fit, ErrCount
  );

  modport slave (
    input  InValid, BusImm, Ctrl, OutReady, ClearErr,
    output InReady, OutValid, Imm26, Fit, ErrCount
  );

endinterface

// File: rtl/imm_fit_check.sv
// Packs a 64-bit immediate into the 26-bit instruction field for the selected format and flags exact fit.
// Purely combinational, no handshake; the field is packed even when the value does not fit.
module imm_fit_check
  import imm_encoder_pkg::*;
(
  input  logic [BUS_W-1:0] busImm,
  input  ctrl_t            ctrl,
  output logic [IMM_W-1:0] imm26,
  output logic             fit
);

  always_comb begin
    imm26 = '0;
    fit   = 1'b0;
    case (ctrl)
      CTRL_I: begin
        imm26[I_LSB +: I_W] = busImm[I_W-1:0];
        fit                 = fitsUnsigned(busImm, I_W);
      end
      CTRL_D: begin
        imm26[D_LSB +: D_W] = busImm[D_W-1:0];
        fit                 = fitsSigned(busImm, D_W);
      end
      CTRL_B: begin
        imm26[B_LSB +: B_W] = busImm[B_W-1:0];
        fit                 = fitsSigned(busImm, B_W);
      end
      CTRL_CB: begin
        imm26[CB_LSB +: CB_W] = busImm[CB_W-1:0];
        fit                   = fitsSigned(busImm, CB_W);
      end
      default: begin
        imm26 = '0;
        fit   = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/imm_encoder.sv
// Two-stage immediate encoder: request register, fit check, result register; 2-cycle latency.
// Full throughput; a stalled result holds stable and stage 1 stops accepting once both stages are full.
module imm_encoder
  import imm_encoder_pkg::*;
(
  input  logic         CLK,
  input  logic         Reset_L,
  imm_encoder_if.slave bus
);

  logic             s1Valid;
  logic [BUS_W-1:0] s1Imm;
  ctrl_t            s1Ctrl;
  logic             s2Valid;
  logic [IMM_W-1:0] s2Imm26;
  logic             s2Fit;
  logic [ERR_W-1:0] errCount;

  logic [IMM_W-1:0] packedImm;
  logic             packedFit;
  logic             s2Advance;
  logic             s1Advance;
  logic             outXfer;

  assign outXfer   = s2Valid && bus.OutReady;
  assign s2Advance = !s2Valid || bus.OutReady;
  assign s1Advance = !s1Valid || s2Advance;

  imm_fit_check uFitCheck (
    .busImm (s1Imm),
    .ctrl   (s1Ctrl),
    .imm26  (packedImm),
    .fit    (packedFit)
  );

  always_ff @(posedge CLK or negedge Reset_L) begin
    if (!Reset_L) begin
      s1Valid <= 1'b0;
      s1Imm   <= '0;
      s1Ctrl  <= CTRL_I;
    end else if (s1Advance) begin
      s1Valid <= bus.InValid;
      if (bus.InValid) begin
        s1Imm  <= bus.BusImm;
        s1Ctrl <= bus.Ctrl;
      end
    end
  end

  // Data only loads with a real entry so the output bus does not churn on bubbles.
  always_ff @(posedge CLK or negedge Reset_L) begin
    if (!Reset_L) begin
      s2Valid <= 1'b0;
      s2Imm26 <= '0;
      s2Fit   <= 1'b0;
    end else if (s2Advance) begin
      s2Valid <= s1Valid;
      if (s1Valid) begin
        s2Imm26 <= packedImm;
        s2Fit   <= packedFit;
      end
    end
  end

  always_ff @(posedge CLK or negedge Reset_L) begin
    if (!Reset_L) begin
      errCount <= '0;
    end else if (bus.ClearErr) begin
      errCount <= '0;
    end else if (outXfer && !s2Fit && (errCount != ERR_MAX)) begin
      errCount <= errCount + 1'b1;
    end
  end

  assign bus.InReady  = s1Advance;
  assign bus.OutValid = s2Valid;
  assign bus.Imm26    = s2Imm26;
  assign bus.Fit      = s2Fit;
  assign bus.ErrCount = errCount;

  stallHold: assert property (@(posedge CLK) disable iff (!Reset_L)
    (s2Valid && !bus.OutReady) |=> (s2Valid && $stable(s2Imm26) && $stable(s2Fit)));

  // A fitting value must be recoverable from the packed field alone.
  roundTrip: assert property (@(posedge CLK) disable iff (!Reset_L)
    (s1Valid && packedFit) |-> (extendImm(packedImm, s1Ctrl) == s1Imm));

endmodule

// File: tb/tb_imm_encoder.sv
// Scoreboard bench for imm_encoder: accepted requests queue a modelled result, delivered results are compared in order.
module tb_imm_encoder;
  import imm_encoder_pkg::*;

  typedef struct {
    logic [25:0] imm;
    logic        fit;
    logic [63:0] req;
    ctrl_t       ctrl;
  } res_t;

  localparam longint D_LO  = -256;
  localparam longint D_HI  = 255;
  localparam longint B_LO  = -33554432;
  localparam longint B_HI  = 33554431;
  localparam longint CB_LO = -262144;
  localparam longint CB_HI = 262143;
  localparam logic [63:0] ALL1 = '1;

  logic CLK     = 1'b0;
  logic Reset_L = 1'b1;

  imm_encoder_if bus();
  imm_encoder dut (.CLK(CLK), .Reset_L(Reset_L), .bus(bus));

  always #5 CLK = ~CLK;

  int   tests    = 0;
  int   fails    = 0;
  int   cycNum   = 0;
  int   errModel = 0;
  res_t expQ[$];
  res_t gotQ[$];
  int   gotCyc[$];

  function automatic res_t model(input logic [63:0] b, input ctrl_t c);
    res_t   r;
    longint v;
    v      = longint'(b);
    r.req  = b;
    r.ctrl = c;
    r.imm  = '0;
    r.fit  = 1'b0;
    case (c)
      CTRL_I:  begin r.imm = {4'b0, b[11:0], 10'b0}; r.fit = (b < 64'd4096); end
      CTRL_D:  begin r.imm = {5'b0, b[8:0], 12'b0};  r.fit = (v >= D_LO) && (v <= D_HI); end
      CTRL_B:  begin r.imm = b[25:0];                r.fit = (v >= B_LO) && (v <= B_HI); end
      default: begin r.imm = {2'b0, b[18:0], 5'b0};  r.fit = (v >= CB_LO) && (v <= CB_HI); end
    endcase
    return r;
  endfunction

  function automatic logic [63:0] pickBus(input ctrl_t c, input int sel);
    longint      lo, hi;
    logic [63:0] span, r;
    case (c)
      CTRL_I:  begin lo = 0;     hi = 4095;  end
      CTRL_D:  begin lo = D_LO;  hi = D_HI;  end
      CTRL_B:  begin lo = B_LO;  hi = B_HI;  end
      default: begin lo = CB_LO; hi = CB_HI; end
    endcase
    span = 64'(hi - lo + 1);
    case (sel)
      0:       r = 64'(lo);
      1:       r = 64'(hi);
      2:       r = 64'(lo - 1);
      3:       r = 64'(hi + 1);
      4:       r = {$urandom, $urandom};
      default: r = 64'(lo) + ({$urandom, $urandom} % span);
    endcase
    return r;
  endfunction

  // Handshakes are judged at the falling edge, i.e. on what the next rising edge will transfer.
  task automatic cycle();
    res_t g;
    @(negedge CLK);
    if (bus.InValid && bus.InReady) expQ.push_back(model(bus.BusImm, bus.Ctrl));
    if (bus.OutValid && bus.OutReady) begin
      g.imm  = bus.Imm26;
      g.fit  = bus.Fit;
      g.req  = '0;
      g.ctrl = CTRL_I;
      gotQ.push_back(g);
      gotCyc.push_back(cycNum);
    end
    @(posedge CLK);
    #1;
    cycNum++;
  endtask

  task automatic sendReq(input logic [63:0] b, input ctrl_t c, output bit ok);
    int n;
    bus.InValid = 1'b1;
    bus.BusImm  = b;
    bus.Ctrl    = c;
    ok = 1'b0;
    for (int i = 0; i < 50 && !ok; i++) begin
      n = expQ.size();
      cycle();
      if (expQ.size() != n) ok = 1'b1;
    end
    bus.InValid = 1'b0;
  endtask

  task automatic drainTo(input int n);
    bus.OutReady = 1'b1;
    for (int i = 0; i < 100 && gotQ.size() < n; i++) cycle();
  endtask

  task automatic test_reset();
    #2 Reset_L = 1'b0;
    #1;
    tests++; if (bus.OutValid !== 1'b0) begin fails++; $display("FAIL reset_outvalid: got %0b want 0", bus.OutValid); end
    tests++; if (bus.ErrCount !== 8'd0) begin fails++; $display("FAIL reset_errcount: got %0d want 0", bus.ErrCount); end
    tests++; if (bus.Imm26 !== 26'd0) begin fails++; $display("FAIL reset_imm26: got %0h want 0", bus.Imm26); end
    tests++; if (bus.Fit !== 1'b0) begin fails++; $display("FAIL reset_fit: got %0b want 0", bus.Fit); end
    repeat (2) @(posedge CLK);
    @(negedge CLK) Reset_L = 1'b1;
    @(posedge CLK);
    #1;
    tests++; if (bus.InReady !== 1'b1) begin fails++; $display("FAIL reset_inready: got %0b want 1", bus.InReady); end
    tests++; if (bus.OutValid !== 1'b0) begin fails++; $display("FAIL reset_outvalid_rel: got %0b want 0", bus.OutValid); end
  endtask

  task automatic test_latency();
    bit ok;
    bus.OutReady = 1'b1;
    sendReq(64'h7FF, CTRL_I, ok);
    tests++; if (!ok) begin fails++; $display("FAIL lat_accept: got accepted=%0b want 1", ok); end
    tests++; if (bus.OutValid !== 1'b0) begin fails++; $display("FAIL lat_early: got OutValid=%0b want 0", bus.OutValid); end
    cycle();
    tests++; if (bus.OutValid !== 1'b1) begin fails++; $display("FAIL lat_valid: got OutValid=%0b want 1", bus.OutValid); end
    tests++; if (bus.Imm26 !== 26'h1FFC00) begin fails++; $display("FAIL lat_imm: got %0h want 1ffc00", bus.Imm26); end
    tests++; if (bus.Fit !== 1'b1) begin fails++; $display("FAIL lat_fit: got %0b want 1", bus.Fit); end
    drainTo(1);
    gotQ.delete();
    expQ.delete();
  endtask

  task automatic test_vectors();
    res_t tbl[5];
    res_t g;
    bit   ok;
    tbl[0] = '{imm: 26'h200000,  fit: 1'b1, req: 64'h800,                 ctrl: CTRL_I};
    tbl[1] = '{imm: 26'h3FFC00,  fit: 1'b0, req: ALL1,                    ctrl: CTRL_I};
    tbl[2] = '{imm: 26'h100000,  fit: 1'b1, req: 64'hFFFF_FFFF_FFFF_FF00, ctrl: CTRL_D};
    tbl[3] = '{imm: 26'h1FFFFFF, fit: 1'b1, req: 64'h1FF_FFFF,            ctrl: CTRL_B};
    tbl[4] = '{imm: 26'h2000000, fit: 1'b1, req: 64'hFFFF_FFFF_FE00_0000, ctrl: CTRL_B};
    for (int k = 0; k < 5; k++) begin
      sendReq(tbl[k].req, tbl[k].ctrl, ok);
      drainTo(1);
      tests++;
      if (!ok || gotQ.size() != 1) begin
        fails++; $display("FAIL vec%0d_delivery: got accepted=%0b results=%0d want 1 result", k, ok, gotQ.size());
      end else begin
        g = gotQ.pop_front();
        tests++; if (g.imm !== tbl[k].imm) begin fails++; $display("FAIL vec%0d_imm: got %0h want %0h", k, g.imm, tbl[k].imm); end
        tests++; if (g.fit !== tbl[k].fit) begin fails++; $display("FAIL vec%0d_fit: got %0b want %0b", k, g.fit, tbl[k].fit); end
        if (tbl[k].fit) begin
          tests++; if (extendImm(g.imm, tbl[k].ctrl) !== tbl[k].req) begin fails++; $display("FAIL vec%0d_roundtrip: got %0h want %0h", k, extendImm(g.imm, tbl[k].ctrl), tbl[k].req); end
        end
        if (!tbl[k].fit && errModel < 255) errModel++;
      end
      gotQ.delete();
      expQ.delete();
    end
    tests++; if (bus.ErrCount !== 8'(errModel)) begin fails++; $display("FAIL vec_errcount: got %0d want %0d", bus.ErrCount, errModel); end
    bus.ClearErr = 1'b1;
    cycle();
    bus.ClearErr = 1'b0;
    errModel = 0;
    tests++; if (bus.ErrCount !== 8'd0) begin fails++; $display("FAIL clear_errcount: got %0d want 0", bus.ErrCount); end
    sendReq(64'h40000, CTRL_CB, ok);
    tests++; if (bus.ErrCount !== 8'd0) begin fails++; $display("FAIL cb_err_before: got %0d want 0", bus.ErrCount); end
    drainTo(1);
    tests++;
    if (gotQ.size() != 1) begin
      fails++; $display("FAIL cb_delivery: got %0d results want 1", gotQ.size());
    end else begin
      g = gotQ.pop_front();
      tests++; if (g.imm !== 26'h800000) begin fails++; $display("FAIL cb_imm: got %0h want 800000", g.imm); end
      tests++; if (g.fit !== 1'b0) begin fails++; $display("FAIL cb_fit: got %0b want 0", g.fit); end
    end
    errModel = 1;
    tests++; if (bus.ErrCount !== 8'd1) begin fails++; $display("FAIL cb_err_after: got %0d want 1", bus.ErrCount); end
    gotQ.delete();
    expQ.delete();
  endtask

  task automatic test_backpressure();
    logic [63:0] rb[3];
    ctrl_t       rc[3];
    res_t        first, g, e;
    int          idx, n;
    rb[0] = 64'd5;                   rc[0] = CTRL_D;
    rb[1] = 64'hFFFF_FFFF_FFFF_FFFD; rc[1] = CTRL_CB;
    rb[2] = 64'h123456;              rc[2] = CTRL_B;
    first = model(rb[0], rc[0]);
    gotQ.delete(); expQ.delete(); gotCyc.delete();
    bus.OutReady = 1'b0;
    idx = 0;
    bus.InValid = 1'b1; bus.BusImm = rb[0]; bus.Ctrl = rc[0];
    for (int c = 0; c < 5; c++) begin
      n = expQ.size();
      cycle();
      if (expQ.size() != n) begin
        idx++;
        if (idx < 3) begin bus.BusImm = rb[idx]; bus.Ctrl = rc[idx]; end
        else bus.InValid = 1'b0;
      end
      if (c >= 1) begin
        tests++;
        if (bus.OutValid !== 1'b1 || bus.Imm26 !== first.imm || bus.Fit !== first.fit) begin
          fails++; $display("FAIL bp_hold%0d: got v=%0b imm=%0h fit=%0b want v=1 imm=%0h fit=%0b", c, bus.OutValid, bus.Imm26, bus.Fit, first.imm, first.fit);
        end
      end
    end
    tests++; if (idx != 2) begin fails++; $display("FAIL bp_accepted: got %0d want 2", idx); end
    tests++; if (bus.InReady !== 1'b0) begin fails++; $display("FAIL bp_inready: got %0b want 0", bus.InReady); end
    bus.OutReady = 1'b1;
    for (int i = 0; i < 20 && gotQ.size() < 3; i++) begin
      n = expQ.size();
      cycle();
      if (expQ.size() != n) begin idx++; bus.InValid = 1'b0; end
    end
    bus.InValid = 1'b0;
    tests++;
    if (gotQ.size() != 3 || expQ.size() != 3) begin
      fails++; $display("FAIL bp_count: got %0d results %0d accepted want 3", gotQ.size(), expQ.size());
    end else begin
      for (int k = 0; k < 3; k++) begin
        g = gotQ.pop_front(); e = expQ.pop_front();
        tests++; if (g.imm !== e.imm || g.fit !== e.fit) begin fails++; $display("FAIL bp_order%0d: got %0h/%0b want %0h/%0b", k, g.imm, g.fit, e.imm, e.fit); end
        if (!e.fit && errModel < 255) errModel++;
      end
      tests++; if (gotCyc[1] - gotCyc[0] != 1 || gotCyc[2] - gotCyc[1] != 1) begin fails++; $display("FAIL bp_rate: got cycles %0d %0d %0d want consecutive", gotCyc[0], gotCyc[1], gotCyc[2]); end
    end
    gotQ.delete(); expQ.delete(); gotCyc.delete();
  endtask

  task automatic test_back_to_back();
    res_t  g, e;
    ctrl_t c2;
    int    n, sent;
    sent = 0;
    for (int c = 0; c < 400; c++) begin
      if (!bus.InValid && sent < 150 && $urandom_range(0, 9) < 7) begin
        c2 = ctrl_t'($urandom_range(0, 3));
        bus.BusImm  = pickBus(c2, int'($urandom_range(0, 5)));
        bus.Ctrl    = c2;
        bus.InValid = 1'b1;
      end
      bus.OutReady = ($urandom_range(0, 3) != 0);
      n = expQ.size();
      cycle();
      if (expQ.size() != n) begin sent++; bus.InValid = 1'b0; end
    end
    bus.InValid = 1'b0;
    drainTo(expQ.size());
    tests++; if (gotQ.size() != expQ.size()) begin fails++; $display("FAIL b2b_count: got %0d results want %0d", gotQ.size(), expQ.size()); end
    while (gotQ.size() > 0 && expQ.size() > 0) begin
      g = gotQ.pop_front(); e = expQ.pop_front();
      tests++; if (g.imm !== e.imm) begin fails++; $display("FAIL b2b_imm: req %0h ctrl %0d got %0h want %0h", e.req, e.ctrl, g.imm, e.imm); end
      tests++; if (g.fit !== e.fit) begin fails++; $display("FAIL b2b_fit: req %0h ctrl %0d got %0b want %0b", e.req, e.ctrl, g.fit, e.fit); end
      if (e.fit) begin
        tests++; if (extendImm(g.imm, e.ctrl) !== e.req) begin fails++; $display("FAIL b2b_roundtrip: got %0h want %0h", extendImm(g.imm, e.ctrl), e.req); end
      end
      if (!e.fit && errModel < 255) errModel++;
    end
    tests++; if (bus.ErrCount !== 8'(errModel)) begin fails++; $display("FAIL b2b_errcount: got %0d want %0d", bus.ErrCount, errModel); end
    gotQ.delete(); expQ.delete();
  endtask

  task automatic test_saturate();
    int n, sent;
    bit ok;
    bus.OutReady = 1'b1;
    bus.ClearErr = 1'b1;
    cycle();
    bus.ClearErr = 1'b0;
    errModel = 0;
    sent = 0;
    bus.InValid = 1'b1; bus.BusImm = ALL1; bus.Ctrl = CTRL_I;
    for (int i = 0; i < 600 && gotQ.size() < 256; i++) begin
      n = expQ.size();
      cycle();
      if (expQ.size() != n) begin
        sent++;
        if (sent == 256) bus.InValid = 1'b0;
      end
    end
    bus.InValid = 1'b0;
    tests++; if (gotQ.size() != 256) begin fails++; $display("FAIL sat_count: got %0d results want 256", gotQ.size()); end
    foreach (expQ[k]) if (!expQ[k].fit && errModel < 255) errModel++;
    tests++; if (bus.ErrCount !== 8'(errModel)) begin fails++; $display("FAIL sat_errcount: got %0d want %0d", bus.ErrCount, errModel); end
    gotQ.delete(); expQ.delete();
    bus.OutReady = 1'b0;
    sendReq(ALL1, CTRL_I, ok);
    for (int i = 0; i < 10 && !bus.OutValid; i++) cycle();
    bus.OutReady = 1'b1;
    bus.ClearErr = 1'b1;
    cycle();
    bus.ClearErr = 1'b0;
    errModel = 0;
    tests++; if (!ok || gotQ.size() != 1) begin fails++; $display("FAIL clr_xfer: got accepted=%0b results=%0d want 1", ok, gotQ.size()); end
    tests++; if (bus.ErrCount !== 8'd0) begin fails++; $display("FAIL clr_priority: got %0d want 0", bus.ErrCount); end
    gotQ.delete(); expQ.delete();
  endtask

  task automatic test_reset_inflight();
    bit ok1, ok2;
    sendReq(ALL1, CTRL_I, ok1);
    drainTo(1);
    tests++; if (bus.ErrCount !== 8'd1) begin fails++; $display("FAIL rst_pre_err: got %0d want 1", bus.ErrCount); end
    gotQ.delete(); expQ.delete();
    bus.OutReady = 1'b0;
    sendReq(64'h10, CTRL_D, ok1);
    sendReq(64'h20, CTRL_D, ok2);
    tests++; if (!ok1 || !ok2) begin fails++; $display("FAIL rst_inflight: got accepted=%0b%0b want 11", ok1, ok2); end
    #2 Reset_L = 1'b0;
    #1;
    tests++; if (bus.OutValid !== 1'b0) begin fails++; $display("FAIL rst_outvalid: got %0b want 0", bus.OutValid); end
    tests++; if (bus.ErrCount !== 8'd0) begin fails++; $display("FAIL rst_errcount: got %0d want 0", bus.ErrCount); end
    tests++; if (bus.Imm26 !== 26'd0 || bus.Fit !== 1'b0) begin fails++; $display("FAIL rst_outputs: got %0h/%0b want 0/0", bus.Imm26, bus.Fit); end
    repeat (2) @(posedge CLK);
    @(negedge CLK) Reset_L = 1'b1;
    @(posedge CLK);
    #1;
    errModel = 0;
    gotQ.delete(); expQ.delete();
    tests++; if (bus.InReady !== 1'b1) begin fails++; $display("FAIL rst_inready: got %0b want 1", bus.InReady); end
    bus.OutReady = 1'b1;
    repeat (10) cycle();
    tests++; if (gotQ.size() != 0 || bus.OutValid !== 1'b0) begin fails++; $display("FAIL rst_stale: got %0d results OutValid=%0b want 0/0", gotQ.size(), bus.OutValid); end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.InValid  = 1'b0;
    bus.BusImm   = '0;
    bus.Ctrl     = CTRL_I;
    bus.OutReady = 1'b0;
    bus.ClearErr = 1'b0;
    test_reset();
    test_latency();
    test_vectors();
    test_backpressure();
    test_back_to_back();
    test_saturate();
    test_reset_inflight();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
